// File: rtl/intc_pkg.sv
// intc_pkg: shared types and the source-arbitration helper for the interrupt controller.
package intc_pkg;
  localparam int NUM_SRC = 2;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} intc_state_t;
  typedef enum logic [1:0] {SRC_NONE = 2'b00, SRC_KEY = 2'b01, SRC_ETH = 2'b10} intc_src_t;
  function automatic logic [1:0] pick(input logic [1:0] pend, input logic eth_first);
    return pend == 2'b11 ? (eth_first ? SRC_ETH : SRC_KEY) : pend[0] ? SRC_KEY : pend[1] ? SRC_ETH : SRC_NONE;
  endfunction
endpackage

// File: rtl/intc_sync_edge.sv
// intc_sync_edge: multi-flop synchroniser for an async level plus a one-cycle rising-edge pulse.
module intc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/intc_arbiter.sv
// intc_arbiter: key/eth interrupt controller with pending latches, overrun counters and request FSM.
// Define INTC_ROUND_ROBIN_EN for rotating priority; default is fixed key-over-eth priority.
module intc_arbiter
  import intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32,
  parameter int OVF_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              irq_key,
  input  logic              irq_eth,
  input  logic [DATA_W-1:0] key_data,
  input  logic [DATA_W-1:0] eth_data,
  input  logic              int_ack,
  input  logic              rti,
  input  logic              rsi,
  output logic              interrupt,
  output logic [DATA_W-1:0] src_data,
  output logic [1:0]        active_src,
  output logic [1:0]        pending,
  output logic [OVF_W-1:0]  ovf_key,
  output logic [OVF_W-1:0]  ovf_eth
);
`ifdef INTC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  intc_state_t state;
  logic [NUM_SRC-1:0] irq_v, rise, clr, ovr;
  logic [DATA_W-1:0] in_data [NUM_SRC];
  logic [DATA_W-1:0] data_q [NUM_SRC];
  logic [OVF_W-1:0] ovf_q [NUM_SRC];
  logic eth_first;
  assign irq_v = {irq_eth, irq_key};
  assign in_data[0] = key_data;
  assign in_data[1] = eth_data;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    intc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst_n(rst_n), .async_in(irq_v[g]), .rise(rise[g])
    );
  end
  // active_src encoding doubles as the pending-bit mask of the winner
  assign clr = (state == REQ && int_ack) ? active_src : (state == SERVICE && rsi) ? 2'b11 : 2'b00;
  assign ovr = rise & pending & ~clr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= '0;
        ovf_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        pending[i] <= rise[i] | (pending[i] & ~clr[i]);
        if (rise[i] && !ovr[i]) data_q[i] <= in_data[i];
        if (ovr[i] && ovf_q[i] != '1) ovf_q[i] <= ovf_q[i] + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      interrupt  <= 1'b0;
      active_src <= SRC_NONE;
      src_data   <= '0;
      eth_first  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|pending) begin
          active_src <= pick(pending, RR & eth_first);
          interrupt  <= 1'b1;
          state      <= REQ;
        end
        REQ: if (int_ack) begin
          src_data  <= active_src == SRC_ETH ? data_q[1] : data_q[0];
          eth_first <= active_src == SRC_KEY;
          interrupt <= 1'b0;
          state     <= SERVICE;
        end
        SERVICE: if (rti || rsi) begin
          active_src <= SRC_NONE;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign ovf_key = ovf_q[0];
  assign ovf_eth = ovf_q[1];
endmodule
